// File: rtl/cc_pkg.sv
// Shared definitions for the cc1_xcorr cross-correlation lag estimator.
// Holds the default geometry, the index width and the controller state type.
package cc_pkg;

  localparam int N_DEF       = 1024;
  localparam int MAX_LAG_DEF = 32;
  localparam int ACC_W_DEF   = 48;
  localparam int LAG_W       = 16;
  localparam int SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_e;

endpackage

// File: rtl/cc1_xcorr_if.sv
// Sample/result bundle between a microphone-pair front end and cc1_xcorr.
// The master drives the block start and samples; the slave returns the lag.
interface cc1_xcorr_if;
  import cc_pkg::*;

  logic                start;
  logic [SAMPLE_W-1:0] m0;
  logic [SAMPLE_W-1:0] m1;
  logic [LAG_W-1:0]    index;
  logic                done;

  modport master (output start, output m0, output m1, input index, input done);
  modport slave  (input start, input m0, input m1, output index, output done);

endinterface

// File: rtl/cc_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port,
// shaped so synthesis maps it onto a block RAM.
module cc_sample_ram
  import cc_pkg::*;
#(
  parameter int DEPTH = N_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       wAddr_i,
  input  logic [SAMPLE_W-1:0] wData_i,
  input  logic [AW-1:0]       rAddr_i,
  output logic [SAMPLE_W-1:0] rData_o
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wAddr_i] <= wData_i;
    end
  end

  always_ff @(posedge clk) begin
    rData_o <= mem[rAddr_i];
  end

endmodule

// File: rtl/cc1_xcorr.sv
// Streaming cross-correlation lag estimator: buffers N sample pairs, sums
// m0[n]*m1[n+lag] for every lag in -MAX_LAG..+MAX_LAG and reports the best lag.
module cc1_xcorr
  import cc_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MAX_LAG = MAX_LAG_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  cc1_xcorr_if.slave bus
);

  localparam int AW = $clog2(N);
  localparam int JW = AW + 2;
  localparam logic [AW-1:0]           LAST_N = AW'(N - 1);
  localparam logic signed [LAG_W-1:0] LAG_LO = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_HI = LAG_W'(MAX_LAG);

  state_e state_q, state_d;
  logic   accept;
  logic   sumDone;

  logic          we;
  logic [AW-1:0] wAddr;
  logic [AW-1:0] wrAddr_q;

  logic                    issue;
  logic                    issueDone_q;
  logic [AW-1:0]           n_q;
  logic signed [LAG_W-1:0] lag_q;
  logic signed [JW-1:0]    jIdx;
  logic                    inRange;

  logic                    s1Valid_q, s1InRange_q, s1Last_q;
  logic signed [LAG_W-1:0] s1Lag_q;
  logic [AW-1:0]           addr0_q, addr1_q;
  logic                    s2Valid_q, s2InRange_q, s2Last_q;
  logic signed [LAG_W-1:0] s2Lag_q;

  logic [SAMPLE_W-1:0]     rd0, rd1;
  logic signed [31:0]      rd0Ext, rd1Ext, prod;
  logic signed [ACC_W-1:0] prodExt;
  logic signed [ACC_W-1:0] acc_q, sum_q, bestSum_q;
  logic                    sumValid_q;
  logic signed [LAG_W-1:0] sumLag_q, bestLag_q;
  logic                    takeNew;

  logic                    done_q;
  logic signed [LAG_W-1:0] index_q;

  assign accept  = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign sumDone = sumValid_q && (sumLag_q == LAG_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = LOAD;
      LOAD:       if (wrAddr_q == LAST_N) state_d = COMPUTE;
      COMPUTE:    if (sumDone) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Sample 0 lands at address 0 in the accepting cycle; LOAD fills the rest.
  assign we    = accept || (state_q == LOAD);
  assign wAddr = (state_q == LOAD) ? wrAddr_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrAddr_q <= '0;
    end else if (accept) begin
      wrAddr_q <= AW'(1);
    end else if (state_q == LOAD) begin
      wrAddr_q <= wrAddr_q + AW'(1);
    end
  end

  cc_sample_ram #(.DEPTH(N), .AW(AW)) u_ram0 (
    .clk     (clk),
    .we_i    (we),
    .wAddr_i (wAddr),
    .wData_i (bus.m0),
    .rAddr_i (addr0_q),
    .rData_o (rd0)
  );

  cc_sample_ram #(.DEPTH(N), .AW(AW)) u_ram1 (
    .clk     (clk),
    .we_i    (we),
    .wAddr_i (wAddr),
    .wData_i (bus.m1),
    .rAddr_i (addr1_q),
    .rData_o (rd1)
  );

  // One (n, lag) pair per cycle; n sweeps fastest, lag steps once per block.
  assign issue   = (state_q == COMPUTE) && !issueDone_q;
  assign jIdx    = $signed({2'b00, n_q}) + $signed(lag_q[JW-1:0]);
  assign inRange = !jIdx[JW-1] && !jIdx[JW-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      lag_q       <= LAG_LO;
      issueDone_q <= 1'b0;
    end else if (accept) begin
      n_q         <= '0;
      lag_q       <= LAG_LO;
      issueDone_q <= 1'b0;
    end else if (issue) begin
      if (n_q == LAST_N) begin
        n_q <= '0;
        if (lag_q == LAG_HI) begin
          issueDone_q <= 1'b1;
        end else begin
          lag_q <= lag_q + LAG_W'(1);
        end
      end else begin
        n_q <= n_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q   <= 1'b0;
      s1InRange_q <= 1'b0;
      s1Last_q    <= 1'b0;
      s1Lag_q     <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      s2Valid_q   <= 1'b0;
      s2InRange_q <= 1'b0;
      s2Last_q    <= 1'b0;
      s2Lag_q     <= '0;
    end else begin
      s1Valid_q   <= issue;
      s1InRange_q <= inRange;
      s1Last_q    <= (n_q == LAST_N);
      s1Lag_q     <= lag_q;
      addr0_q     <= n_q;
      addr1_q     <= jIdx[AW-1:0];
      s2Valid_q   <= s1Valid_q;
      s2InRange_q <= s1InRange_q;
      s2Last_q    <= s1Last_q;
      s2Lag_q     <= s1Lag_q;
    end
  end

  // Out-of-range terms still flow through the pipe but contribute zero.
  assign rd0Ext  = {{16{rd0[15]}}, rd0};
  assign rd1Ext  = {{16{rd1[15]}}, rd1};
  assign prod    = s2InRange_q ? (rd0Ext * rd1Ext) : 32'sd0;
  assign prodExt = {{(ACC_W-32){prod[31]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      sum_q      <= '0;
      sumValid_q <= 1'b0;
      sumLag_q   <= '0;
    end else begin
      sumValid_q <= 1'b0;
      if (s2Valid_q) begin
        if (s2Last_q) begin
          sum_q      <= acc_q + prodExt;
          sumLag_q   <= s2Lag_q;
          sumValid_q <= 1'b1;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_q + prodExt;
        end
      end
    end
  end

  // Strictly-greater replacement keeps the most negative lag on ties.
  assign takeNew = (sumLag_q == LAG_LO) || (sum_q > bestSum_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      bestSum_q <= '0;
      bestLag_q <= '0;
      done_q    <= 1'b0;
      index_q   <= '0;
    end else begin
      if (accept) begin
        done_q <= 1'b0;
      end
      if (sumValid_q && takeNew) begin
        bestSum_q <= sum_q;
        bestLag_q <= sumLag_q;
      end
      if (sumDone) begin
        done_q  <= 1'b1;
        index_q <= takeNew ? sumLag_q : bestLag_q;
      end
    end
  end

  assign bus.done  = done_q;
  assign bus.index = index_q;

endmodule

// File: tb/tb_cc1_xcorr.sv
// Randomized self-checking bench for cc1_xcorr on a reduced geometry, compared
// against a direct evaluation of the correlation sums for every lag.
module tb_cc1_xcorr;

  localparam int N       = 64;
  localparam int MAX_LAG = 8;
  localparam int ACC_W   = 48;
  localparam int LATENCY = N + (2 * MAX_LAG + 1) * N + 3;
  localparam int LIMIT   = LATENCY + 200;

  logic clk = 1'b0;
  logic rst;

  cc1_xcorr_if bus ();

  cc1_xcorr #(.N(N), .MAX_LAG(MAX_LAG), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int      checks = 0;
  int      failures = 0;
  int      lastIndex = 0;
  shortint sampA [N];
  shortint sampB [N];

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Brute-force argmax over all lags, first lag wins ties.
  function automatic int modelLag();
    longint best = 0;
    longint s;
    int     bestTau = -MAX_LAG;
    for (int tau = -MAX_LAG; tau <= MAX_LAG; tau++) begin
      s = 0;
      for (int n = 0; n < N; n++) begin
        if (n + tau >= 0 && n + tau < N) begin
          s += longint'(sampA[n]) * longint'(sampB[n + tau]);
        end
      end
      if (tau == -MAX_LAG || s > best) begin
        best    = s;
        bestTau = tau;
      end
    end
    return bestTau;
  endfunction

  task automatic makeDelayed(input int d);
    for (int n = 0; n < N; n++) sampA[n] = shortint'($urandom);
    for (int n = 0; n < N; n++) begin
      if (n - d >= 0 && n - d < N) sampB[n] = sampA[n - d];
      else sampB[n] = shortint'($urandom);
    end
  endtask

  task automatic makeSine();
    for (int n = 0; n < N; n++) begin
      sampA[n] = shortint'($rtoi(32767.0 * $sin(6.283185307179586 * n / 64.0)));
      sampB[n] = sampA[n];
    end
  endtask

  task automatic makeZero();
    for (int n = 0; n < N; n++) begin
      sampA[n] = 16'sd0;
      sampB[n] = 16'sd0;
    end
  endtask

  // Called right after a falling edge; streams one block and waits for done.
  task automatic applyStimulus(input string tag, input int loadPoke, input int computePoke,
                               input int abortAt);
    int cyc = 0;
    bit seen = 1'b0;
    int holdErrs = 0;
    int expLag;
    expLag    = modelLag();
    bus.start = 1'b1;
    bus.m0    = sampA[0];
    bus.m1    = sampB[0];
    while (!seen && cyc < LIMIT && cyc != abortAt) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.start = (cyc == loadPoke) || (cyc == computePoke);
      if (cyc < N) begin
        bus.m0 = sampA[cyc];
        bus.m1 = sampB[cyc];
      end else begin
        bus.m0 = 16'($urandom);
        bus.m1 = 16'($urandom);
      end
      if (cyc == 1) checkOutput({tag, ".doneFall"}, bus.done, 0);
      if (bus.done) seen = 1'b1;
      else if (int'($signed(bus.index)) != lastIndex) holdErrs++;
    end
    if (cyc == abortAt) return;
    checkOutput({tag, ".timeout"}, seen, 1);
    checkOutput({tag, ".latency"}, cyc, LATENCY);
    checkOutput({tag, ".indexHold"}, holdErrs, 0);
    checkOutput({tag, ".index"}, $signed(bus.index), expLag);
    lastIndex = expLag;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.m0    = '0;
    bus.m1    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.done", bus.done, 0);
    checkOutput("reset.index", $signed(bus.index), 0);
    rst = 1'b0;
    @(negedge clk);

    makeSine();
    applyStimulus("sine", -1, -1, -1);
    repeat (4) @(negedge clk);

    makeDelayed(5);
    applyStimulus("delay+5", -1, -1, -1);
    makeDelayed(-7);
    applyStimulus("delay-7", -1, -1, -1);

    makeDelayed(MAX_LAG);
    applyStimulus("delayMax", -1, -1, -1);
    makeDelayed(0);
    applyStimulus("backToBack", -1, -1, -1);

    makeZero();
    applyStimulus("zero", -1, -1, -1);

    makeDelayed(4);
    applyStimulus("abort", -1, -1, N + 200);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midReset.done", bus.done, 0);
    checkOutput("midReset.index", $signed(bus.index), 0);
    rst       = 1'b0;
    lastIndex = 0;
    @(negedge clk);
    makeDelayed(3);
    applyStimulus("afterReset", -1, -1, -1);

    makeDelayed(2);
    applyStimulus("startPoke", 10, N + 50, -1);

    for (int r = 0; r < 3; r++) begin
      makeDelayed(int'($urandom_range(2 * MAX_LAG)) - MAX_LAG);
      applyStimulus($sformatf("rand%0d", r), -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc1_xcorr.md
# cc1_xcorr

Streaming cross-correlation lag estimator. It captures a block of N signed 16-bit sample pairs (m0 = reference channel, m1 = compared channel), evaluates the correlation sum at every lag in −MAX_LAG..+MAX_LAG, and reports the lag with the largest sum as a signed 16-bit index. It sits in the audio-localisation path, where one instance per microphone pair feeds time-difference-of-arrival values to the position math.

## Interface
- N, 1024: samples per block (power of two).
- MAX_LAG, 32: largest lag magnitude searched; must be less than N.
- ACC_W, 48: signed accumulator width; must be at least 32 + log2(N).
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a block. The sample on m0/m1 in this same cycle is sample 0.
- m0, input, 16: signed reference sample.
- m1, input, 16: signed compared sample.
- index, output, 16: signed best lag, sign-extended.
- done, output, 1: result valid. Level signal, held high.

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE / DONE → LOAD when start=1. Sample 0 is written in that cycle.
- LOAD: m0[k] and m1[k] are written to two N×16 buffers, one sample per cycle for N consecutive cycles (k = 0..N−1). Inputs are not qualified; every cycle is a sample. After sample N−1, the block enters COMPUTE.
- COMPUTE: for each lag τ from −MAX_LAG up to +MAX_LAG, S(τ) = Σ m0[n]·m1[n+τ] over n = 0..N−1.
  - Terms with n+τ outside 0..N−1 contribute 0 (no wrap-around).
  - Products are full signed 32-bit; sums are accumulated at ACC_W bits with no saturation.
- Best-lag tracking: after each lag completes, replace best when S(τ) > best_S (strictly greater).
  - Ties therefore keep the more negative lag.
  - The first lag, −MAX_LAG, always initialises best.
- Sign convention: positive index means m1 is delayed relative to m0, i.e. m1[n] = m0[n−d] gives index = +d.
- DONE: index is loaded with the best lag and done=1. Both hold until the next accepted start.
- start is ignored in LOAD and COMPUTE.
- Reset (any state, including mid-LOAD or mid-COMPUTE): state = IDLE, done = 0, index = 0, accumulators and best cleared. Buffer contents are don't-care.

## Timing
- done and index are registered outputs. Reset values: done = 0, index = 0.
- Accepted start in cycle t0 → samples are captured in cycles t0 .. t0+N−1.
- COMPUTE issues one buffer address pair per cycle: (2·MAX_LAG+1)·N issue cycles. Out-of-range terms still consume a cycle.
- The MAC pipeline has 3 stages: address, synchronous RAM read, multiply-accumulate. Each lag's sum completes 3 cycles after its last issue; the pipeline overlaps across lags.
- done rises exactly at t0 + N + (2·MAX_LAG+1)·N + 3. With defaults, that is t0 + 67587.
- done falls in the cycle after an accepted start. index keeps its old value until the new result lands.

## Structure
- Package cc_pkg holds:
  - default N, MAX_LAG, ACC_W;
  - the state enum;
  - a LAG_W constant (16) for index.
- Sub-module cc_sample_ram: single-write-port, single-read-port N×16 RAM with synchronous read, instantiated twice (m0, m1) to infer block RAM.
- The top level contains the FSM, address/lag counters, range gating, MAC, and best-lag comparator.

## Test plan
- m1 = m0, both a 16-bit-amplitude sine of period 64 → index = 0. done rises exactly 67587 cycles after start.
- m1[n] = m0[n−5] (pseudo-random samples) → index = +5. m1[n] = m0[n+7] → index = −7.
- Delay of exactly +MAX_LAG (32) → index = +32. A second block with delay 0 run back-to-back → index = 0. done drops for one run, and index stays 32 until the new done.
- All-zero inputs → every S(τ) = 0 → tie rule gives index = −32.
- rst pulsed mid-COMPUTE → next cycle done = 0, index = 0, state IDLE. A fresh block with delay +3 then gives index = +3.
- start pulsed during LOAD and during COMPUTE → ignored. Result and done timing are identical to the undisturbed run.
